// File: rtl/jtag_user_pkg.sv
// jtag_user_pkg: TAP state encoding and chain identifiers shared by the JTAG user-DR controller.
package jtag_user_pkg;

    // Encoding matches the common Xilinx/IEEE 1149.1 tracker convention (TLR = 4'hF).
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic CHAIN_USER3 = 1'b0;
    localparam logic CHAIN_USER2 = 1'b1;

endpackage

// File: rtl/jtag_tap_tracker.sv
// jtag_tap_tracker: mirrors the 16-state TAP controller, stepping once per oversampled TCK rise.
module jtag_tap_tracker
    import jtag_user_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tck_rise,
    input  logic       tms,
    input  logic       jtag_reset,
    output tap_state_t state
);

    tap_state_t r_state, w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= TEST_LOGIC_RESET;
        else        r_state <= w_next;
    end

    // jtag_reset has priority over any TCK activity in the same cycle.
    always_comb begin
        w_next = r_state;
        if (jtag_reset) begin
            w_next = TEST_LOGIC_RESET;
        end else if (tck_rise) begin
            case (r_state)
                TEST_LOGIC_RESET: w_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    w_next = tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_DR:        w_next = tms ? SELECT_IR : CAPTURE_DR;
                CAPTURE_DR:       w_next = tms ? EXIT1_DR  : SHIFT_DR;
                SHIFT_DR:         w_next = tms ? EXIT1_DR  : SHIFT_DR;
                EXIT1_DR:         w_next = tms ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:         w_next = tms ? EXIT2_DR  : PAUSE_DR;
                EXIT2_DR:         w_next = tms ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR:        w_next = tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_IR:        w_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       w_next = tms ? EXIT1_IR  : SHIFT_IR;
                SHIFT_IR:         w_next = tms ? EXIT1_IR  : SHIFT_IR;
                EXIT1_IR:         w_next = tms ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:         w_next = tms ? EXIT2_IR  : PAUSE_IR;
                EXIT2_IR:         w_next = tms ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR:        w_next = tms ? SELECT_DR : RUN_TEST_IDLE;
                default:          w_next = TEST_LOGIC_RESET;
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: rtl/jtag_user_dr_ctrl.sv
// jtag_user_dr_ctrl: fabric-side controller for the USER3/USER2 BSCANE2 chains; oversamples
// the JTAG pins, runs one shared DR and hands completed writes to the core over valid/ready.
module jtag_user_dr_ctrl
    import jtag_user_pkg::*;
#(
    parameter int DR_W     = 32,
    parameter int SYNC_STG = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            jtag_reset,
    input  logic            jtag_tck,
    input  logic            jtag_tms,
    input  logic            jtag_tdi,
    input  logic            jtag_sel1,
    input  logic            jtag_sel2,
    output logic            jtag_tdo,
    input  logic [DR_W-1:0] cap_data0,
    input  logic [DR_W-1:0] cap_data1,
    output logic            upd_valid,
    input  logic            upd_ready,
    output logic            upd_chain,
    output logic [DR_W-1:0] upd_data,
    output logic            err_ovr,
    output logic            err_len,
    input  logic            err_clr
);

    localparam int CW = $clog2(DR_W + 2);

    logic [SYNC_STG-1:0][5:0] r_sync;
    logic                     r_tck_d;
    logic [5:0]               w_s;
    logic                     w_tck_rise, w_tck_fall, w_jrst, w_dr_op;
    logic                     w_cap, w_shift, w_upd, w_len_bad, w_take, w_ovr;
    tap_state_t               w_state;

    logic                     r_active, r_chain, r_tdo;
    logic [DR_W-1:0]          r_sr;
    logic [CW-1:0]            r_cnt;
    logic                     r_upd_valid, r_upd_chain, r_err_ovr, r_err_len;
    logic [DR_W-1:0]          r_upd_data;

    // Bit order within each stage: {reset, sel2, sel1, tdi, tms, tck}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_tck_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STG-2:0],
                        {jtag_reset, jtag_sel2, jtag_sel1, jtag_tdi, jtag_tms, jtag_tck}};
            r_tck_d <= w_s[0];
        end
    end

    assign w_s        = r_sync[SYNC_STG-1];
    assign w_tck_rise = w_s[0] & ~r_tck_d;
    assign w_tck_fall = ~w_s[0] & r_tck_d;
    assign w_jrst     = w_s[5];
    assign w_dr_op    = w_tck_rise & ~w_jrst;

    jtag_tap_tracker u_tap (
        .clk        (clk),
        .rst_n      (rst_n),
        .tck_rise   (w_tck_rise),
        .tms        (w_s[1]),
        .jtag_reset (w_jrst),
        .state      (w_state)
    );

    assign w_cap     = w_dr_op & (w_state == CAPTURE_DR);
    assign w_shift   = w_dr_op & (w_state == SHIFT_DR) & r_active;
    assign w_upd     = w_dr_op & (w_state == UPDATE_DR) & r_active;
    assign w_len_bad = r_cnt != CW'(DR_W);
    assign w_take    = w_upd & ~w_len_bad & (~r_upd_valid | upd_ready);
    assign w_ovr     = w_upd & ~w_len_bad & r_upd_valid & ~upd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_chain  <= CHAIN_USER3;
            r_sr     <= '0;
            r_cnt    <= '0;
        end else if (w_jrst) begin
            r_active <= 1'b0;
        end else if (w_cap) begin
            r_active <= w_s[3] | w_s[4];
            if (w_s[3] | w_s[4]) begin
                r_chain <= w_s[3] ? CHAIN_USER3 : CHAIN_USER2;
                r_sr    <= w_s[3] ? cap_data0 : cap_data1;
                r_cnt   <= '0;
            end
        end else if (w_shift) begin
            r_sr  <= {w_s[2], r_sr[DR_W-1:1]};
            r_cnt <= (r_cnt == CW'(DR_W + 1)) ? r_cnt : r_cnt + 1'b1;
        end else if (w_upd) begin
            r_active <= 1'b0;
        end
    end

    // TDO changes only on TCK fall so the host sees a settled bit at the next rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_tdo <= 1'b0;
        else if (w_tck_fall) r_tdo <= r_active & r_sr[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_valid <= 1'b0;
            r_upd_chain <= 1'b0;
            r_upd_data  <= '0;
            r_err_ovr   <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_upd_valid <= w_take | (r_upd_valid & ~upd_ready);
            if (w_take) begin
                r_upd_chain <= r_chain;
                r_upd_data  <= r_sr;
            end
            r_err_ovr <= w_ovr | (r_err_ovr & ~err_clr);
            r_err_len <= (w_upd & w_len_bad) | (r_err_len & ~err_clr);
        end
    end

    assign jtag_tdo  = r_tdo;
    assign upd_valid = r_upd_valid;
    assign upd_chain = r_upd_chain;
    assign upd_data  = r_upd_data;
    assign err_ovr   = r_err_ovr;
    assign err_len   = r_err_len;

endmodule
